// File: rtl/lpc_mailbox_regs.sv
// LPC I/O mailbox: 8-byte register window bridging host reads/writes
// to a host->device TX byte FIFO and a device->host RX byte FIFO.
module lpc_mailbox_regs #(
    parameter logic [15:0] BASE_ADDR  = 16'h0F00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] lpc_addr_i,
    input  logic [7:0]  lpc_wdata_i,
    input  logic        lpc_data_wr_i,
    output logic        lpc_wr_done_o,
    input  logic        lpc_data_req_i,
    output logic [7:0]  lpc_rdata_o,
    output logic        lpc_data_rd_o,
    output logic [3:0]  irq_num_o,
    output logic        interrupt_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ACK  = 2'd1;
    localparam logic [1:0] W_WAIT = 2'd2;

    // R_FETCH gives the one extra cycle between request rise and valid data
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_VALID = 2'd2;
    localparam logic [1:0] R_DONE  = 2'd3;

    logic [1:0]  wst_q, wst_d;
    logic [1:0]  rst_q, rst_d;
    logic        req_prev_q;
    logic [15:0] raddr_q, raddr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_empty_q, rd_empty_d;
    logic [4:0]  ctrl_q, ctrl_d;
    logic [7:0]  scratch_q, scratch_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_unf_q, rx_unf_d;
    logic [3:0]  irq_num_q, irq_num_d;
    logic        int_q, int_d;

    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [7:0]  tx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [7:0]  rx_mem_d [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic wr_fire, w_hit, r_hit, r_is_data, rd_commit;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ovf_set, unf_set;
    logic [2:0] w_off;
    logic [7:0] status;

    assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign w_hit = (lpc_addr_i[15:3] == BASE_ADDR[15:3]);
    assign w_off = lpc_addr_i[2:0];
    assign r_hit = (raddr_q[15:3] == BASE_ADDR[15:3]);
    assign r_is_data = r_hit && (raddr_q[2:0] == 3'd0);

    assign wr_fire   = (wst_q == W_IDLE) && lpc_data_wr_i;
    assign tx_push   = wr_fire && w_hit && (w_off == 3'd0) && !tx_full;
    assign ovf_set   = wr_fire && w_hit && (w_off == 3'd0) && tx_full;
    assign tx_pop    = !tx_empty && tx_ready_i;
    assign rx_push   = rx_valid_i && !rx_full;
    assign rd_commit = (rst_q == R_VALID) && !lpc_data_req_i;
    assign rx_pop    = rd_commit && r_is_data && !rd_empty_q;
    assign unf_set   = rd_commit && r_is_data && rd_empty_q;

    assign status = {4'b0, rx_unf_q, tx_ovf_q, tx_full, !rx_empty};

    always_comb begin
        wst_d     = wst_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        tx_ovf_d  = tx_ovf_q;
        rx_unf_d  = rx_unf_q;
        case (wst_q)
            W_IDLE: begin
                if (lpc_data_wr_i) begin
                    wst_d = W_ACK;
                    if (w_hit) begin
                        case (w_off)
                            3'd1: begin
                                if (lpc_wdata_i[2]) tx_ovf_d = 1'b0;
                                if (lpc_wdata_i[3]) rx_unf_d = 1'b0;
                            end
                            3'd2:    ctrl_d    = lpc_wdata_i[4:0];
                            3'd3:    scratch_d = lpc_wdata_i;
                            default: ;
                        endcase
                    end
                end
            end
            W_ACK:   wst_d = W_WAIT;
            W_WAIT:  if (!lpc_data_wr_i) wst_d = W_IDLE;
            default: wst_d = W_IDLE;
        endcase
        // a new error event wins over a simultaneous W1C
        if (ovf_set) tx_ovf_d = 1'b1;
        if (unf_set) rx_unf_d = 1'b1;
    end

    always_comb begin
        rst_d      = rst_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        rd_empty_d = rd_empty_q;
        case (rst_q)
            R_IDLE: begin
                if (lpc_data_req_i && !req_prev_q) begin
                    raddr_d = lpc_addr_i;
                    rst_d   = R_FETCH;
                end
            end
            R_FETCH: begin
                rst_d      = R_VALID;
                rd_empty_d = rx_empty;
                if (!r_hit) begin
                    rdata_d = 8'hFF;
                end else begin
                    case (raddr_q[2:0])
                        3'd0:    rdata_d = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
                        3'd1:    rdata_d = status;
                        3'd2:    rdata_d = {3'b0, ctrl_q};
                        3'd3:    rdata_d = scratch_q;
                        default: rdata_d = 8'hFF;
                    endcase
                end
            end
            R_VALID: if (!lpc_data_req_i) rst_d = R_DONE;
            default: rst_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = lpc_wdata_i;
            tx_wp_d = tx_wp_q + AW'(1);
        end
        if (tx_pop) tx_rp_d = tx_rp_q + AW'(1);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

        rx_mem_d = rx_mem_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_data_i;
            rx_wp_d = rx_wp_q + AW'(1);
        end
        if (rx_pop) rx_rp_d = rx_rp_q + AW'(1);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        irq_num_d = ctrl_q[3:0];
        int_d     = ctrl_q[4] && !rx_empty;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wst_q      <= W_IDLE;
            rst_q      <= R_IDLE;
            req_prev_q <= 1'b0;
            raddr_q    <= '0;
            rdata_q    <= 8'hFF;
            rd_empty_q <= 1'b0;
            ctrl_q     <= '0;
            scratch_q  <= '0;
            tx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            irq_num_q  <= '0;
            int_q      <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
        end else begin
            wst_q      <= wst_d;
            rst_q      <= rst_d;
            req_prev_q <= lpc_data_req_i;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
            rd_empty_q <= rd_empty_d;
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_unf_q   <= rx_unf_d;
            irq_num_q  <= irq_num_d;
            int_q      <= int_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
        end
    end

    assign lpc_wr_done_o = (wst_q == W_ACK);
    assign lpc_data_rd_o = (rst_q == R_VALID);
    assign lpc_rdata_o   = rdata_q;
    assign irq_num_o     = irq_num_q;
    assign interrupt_o   = int_q;
    assign tx_data_o     = tx_mem_q[tx_rp_q];
    assign tx_valid_o    = !tx_empty;
    assign rx_ready_o    = !rx_full;

endmodule

// File: tb/tb_lpc_mailbox_regs.sv
// Bench for lpc_mailbox_regs: directed scenarios plus random host/device
// traffic checked against a queue-based model of the mailbox.
module tb_lpc_mailbox_regs;

    localparam logic [15:0] BASE = 16'h0F00;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        wr = 1'b0;
    logic        wr_done;
    logic        req = 1'b0;
    logic [7:0]  rdata;
    logic        rd;
    logic [3:0]  irq_num;
    logic        intr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    lpc_mailbox_regs #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .lpc_addr_i(addr), .lpc_wdata_i(wdata),
        .lpc_data_wr_i(wr), .lpc_wr_done_o(wr_done),
        .lpc_data_req_i(req), .lpc_rdata_o(rdata), .lpc_data_rd_o(rd),
        .irq_num_o(irq_num), .interrupt_o(intr),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [4:0] m_ctrl = '0;
    logic [7:0] m_scr = '0;
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_off(input logic [15:0] a);
        int d;
        d = int'(a) - int'(BASE);
        return (d < 0 || d > 7) ? -1 : d;
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        case (m_off(a))
            0: return (rxq.size() == 0) ? 8'h00 : rxq[0];
            1: return {4'b0, m_unf, m_ovf, txq.size() == DEPTH, rxq.size() != 0};
            2: return {3'b0, m_ctrl};
            3: return m_scr;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic m_reset();
        txq.delete();
        rxq.delete();
        m_ctrl = '0;
        m_scr = '0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d);
        int lat = 0;
        @(negedge clk);
        addr = a;
        wdata = d;
        wr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (wr_done) begin
                lat = i;
                break;
            end
        end
        chk("wr_ack_lat", lat, 1);
        case (m_off(a))
            0: if (txq.size() < DEPTH) txq.push_back(d); else m_ovf = 1;
            1: begin
                if (d[2]) m_ovf = 0;
                if (d[3]) m_unf = 0;
            end
            2: m_ctrl = d[4:0];
            3: m_scr = d;
            default: ;
        endcase
        @(negedge clk);
        chk("wr_ack_pulse", wr_done, 0);
        wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_read(input logic [15:0] a, output logic [7:0] got);
        int lat = 0;
        logic [7:0] exp;
        exp = m_read(a);
        @(negedge clk);
        addr = a;
        req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rd) begin
                lat = i;
                break;
            end
        end
        chk("rd_lat", lat, 2);
        got = rdata;
        chk("rd_data", rdata, exp);
        @(negedge clk);
        chk("rd_hold", {rd, rdata}, {1'b1, exp});
        req = 1'b0;
        @(negedge clk);
        chk("rd_drop", rd, 0);
        if (m_off(a) == 0) begin
            if (rxq.size() != 0) void'(rxq.pop_front());
            else m_unf = 1;
        end
        @(negedge clk);
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        chk("rx_ready", rx_ready, rxq.size() < DEPTH);
        rx_data = d;
        rx_valid = 1'b1;
        if (rxq.size() < DEPTH) rxq.push_back(d);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tx_drain_one();
        @(negedge clk);
        chk("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        if (txq.size() != 0) void'(txq.pop_front());
    endtask

    task automatic check_irq();
        repeat (2) @(negedge clk);
        chk("interrupt", intr, m_ctrl[4] && rxq.size() != 0);
        chk("irq_num", irq_num, m_ctrl[3:0]);
    endtask

    initial begin
        logic [7:0] v;
        logic [15:0] a;
        int pick;

        repeat (2) @(negedge clk);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_rd", rd, 0);
        chk("rst_rdata", rdata, 8'hFF);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_int", {irq_num, intr}, 5'h0);
        rst = 1'b0;
        @(negedge clk);

        host_write(BASE + 16'd3, 8'hA5);
        host_read(BASE + 16'd3, v);
        chk("scratch_a5", v, 8'hA5);

        rx_push(8'h11);
        rx_push(8'h22);
        host_write(BASE + 16'd2, 8'h15);
        check_irq();
        chk("irq_on", {intr, irq_num}, {1'b1, 4'h5});
        host_read(BASE, v);
        chk("rx_first", v, 8'h11);
        host_read(BASE, v);
        chk("rx_second", v, 8'h22);
        check_irq();
        chk("irq_off", intr, 0);

        host_read(BASE, v);
        chk("rx_empty_read", v, 8'h00);
        host_read(BASE + 16'd1, v);
        chk("status_unf", v, 8'h08);
        host_write(BASE + 16'd1, 8'h08);
        host_read(BASE + 16'd1, v);
        chk("status_clr", v, 8'h00);

        for (int i = 0; i < 5; i++) host_write(BASE, 8'h30 + 8'(i));
        host_read(BASE + 16'd1, v);
        chk("status_full", v, 8'h06);
        for (int i = 0; i < 5; i++) tx_drain_one();
        host_write(BASE + 16'd1, 8'h04);

        host_read(BASE + 16'd5, v);
        chk("reserved_ff", v, 8'hFF);
        host_read(16'h0060, v);
        chk("oow_ff", v, 8'hFF);
        host_write(16'h0060, 8'h5A);
        host_read(BASE + 16'd3, v);

        for (int it = 0; it < 300; it++) begin
            pick = $urandom_range(0, 9);
            if (pick < 8) a = BASE + 16'(pick);
            else if (pick == 8) a = 16'h0060;
            else a = BASE + 16'd8;
            case ($urandom_range(0, 4))
                0: host_write(a, 8'($urandom));
                1: host_read(a, v);
                2: rx_push(8'($urandom));
                3: tx_drain_one();
                default: check_irq();
            endcase
        end
        check_irq();

        while (rxq.size() < 1) rx_push(8'h77);
        @(negedge clk);
        addr = BASE;
        req = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_rd", rd, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rd", rd, 0);
        chk("async_rdata", rdata, 8'hFF);
        chk("async_fifo", {tx_valid, rx_ready}, 2'b01);
        chk("async_int", {intr, irq_num, wr_done}, 6'h0);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        m_reset();
        host_read(BASE + 16'd1, v);
        chk("post_rst_status", v, 8'h00);
        host_read(BASE, v);
        chk("post_rst_data", v, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
